// File: rtl/rs_issue_sched.sv
// Oldest-first issue scheduler: picks up to three ready RS entries per cycle using an age matrix
// and binds each pick to a free ALU/LS/MULT/BR unit.
module rs_issue_sched #(
  parameter int RS_SIZE  = 16,
  parameter int IDXW     = 4,
  parameter int MULT_LAT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [2:0][RS_SIZE-1:0]    alloc_vec_i,
  input  logic [RS_SIZE-1:0]         entry_ready_i,
  input  logic [RS_SIZE-1:0][1:0]    entry_fu_i,
  input  logic [1:0]                 ls_ready_i,
  input  logic                       squash_i,
  output logic [RS_SIZE-1:0]         issue_en_o,
  output logic [2:0]                 issue_valid_o,
  output logic [2:0][IDXW-1:0]       issue_idx_o,
  output logic [2:0][2:0]            issue_fu_o,
  output logic [1:0]                 mult_busy_o
);

  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);

  typedef logic [IDXW:0] cnt_t;

  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;
  logic [1:0][CW-1:0]              multCnt_q, multCnt_d;

  logic [RS_SIZE-1:0][RS_SIZE-1:0] precedes;
  cnt_t                            classAhead [RS_SIZE][4];
  cnt_t                            cap [4];
  logic [1:0]                      multFree;
  logic [RS_SIZE-1:0]              take;
  logic [RS_SIZE-1:0][1:0]         takeSlot;
  logic [RS_SIZE-1:0][2:0]         takeFu;
  cnt_t                            picksAhead;
  cnt_t                            own;
  logic [1:0]                      multIssue;

  // Allocations are applied slot 2 first so later (younger) slots end up behind earlier ones.
  always_comb begin
    older_d = older_q;
    if (squash_i) begin
      older_d = '0;
    end else begin
      for (int s = 2; s >= 0; s--) begin
        for (int e = 0; e < RS_SIZE; e++) begin
          if (alloc_vec_i[s][e]) begin
            for (int k = 0; k < RS_SIZE; k++) begin
              older_d[e][k] = 1'b0;
              if (k != e) older_d[k][e] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Total order: a one-sided matrix bit decides; equal bits (cleared or corrupted) fall back to lower index.
  always_comb begin
    precedes = '0;
    for (int j = 0; j < RS_SIZE; j++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (j != i) begin
          precedes[j][i] = (older_q[j][i] != older_q[i][j]) ? older_q[j][i] : (j < i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int c = 0; c < 4; c++) classAhead[i][c] = '0;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (entry_ready_i[j] && precedes[j][i]) begin
          classAhead[i][entry_fu_i[j]] = classAhead[i][entry_fu_i[j]] + cnt_t'(1);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) multFree[k] = (multCnt_q[k] == '0);
    cap[0] = cnt_t'(3);
    cap[1] = cnt_t'(ls_ready_i[0]) + cnt_t'(ls_ready_i[1]);
    cap[2] = cnt_t'(multFree[0]) + cnt_t'(multFree[1]);
    cap[3] = cnt_t'(1);
  end

  // Picks taken ahead of an entry equal the sum of per-class picks ahead, each capped by that class's units.
  always_comb begin
    take       = '0;
    takeSlot   = '0;
    takeFu     = '0;
    picksAhead = '0;
    own        = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      picksAhead = '0;
      for (int c = 0; c < 4; c++) begin
        picksAhead = picksAhead + ((classAhead[i][c] < cap[c]) ? classAhead[i][c] : cap[c]);
      end
      own         = classAhead[i][entry_fu_i[i]];
      take[i]     = entry_ready_i[i] && (own < cap[entry_fu_i[i]]) && (picksAhead < cnt_t'(3));
      takeSlot[i] = picksAhead[1:0];
      case (entry_fu_i[i])
        2'b00:   takeFu[i] = own[2:0];
        2'b01:   takeFu[i] = ((own == '0) && ls_ready_i[0]) ? 3'd3 : 3'd4;
        2'b10:   takeFu[i] = ((own == '0) && multFree[0]) ? 3'd5 : 3'd6;
        default: takeFu[i] = 3'd7;
      endcase
    end
  end

  always_comb begin
    issue_en_o    = '0;
    issue_valid_o = '0;
    issue_idx_o   = '0;
    issue_fu_o    = '0;
    multIssue     = '0;
    if (rst_ni && !squash_i) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (take[i]) begin
          issue_en_o[i]                = 1'b1;
          issue_valid_o[takeSlot[i]]   = 1'b1;
          issue_idx_o[takeSlot[i]]     = IDXW'(i);
          issue_fu_o[takeSlot[i]]      = takeFu[i];
          if (takeFu[i] == 3'd5) multIssue[0] = 1'b1;
          if (takeFu[i] == 3'd6) multIssue[1] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if (multIssue[k]) begin
        multCnt_d[k] = MULT_LOAD;
      end else if (multCnt_q[k] != '0) begin
        multCnt_d[k] = multCnt_q[k] - CW'(1);
      end else begin
        multCnt_d[k] = '0;
      end
      mult_busy_o[k] = (multCnt_q[k] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      older_q   <= '0;
      multCnt_q <= '0;
    end else begin
      older_q   <= older_d;
      multCnt_q <= multCnt_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: hand-computed issue slots, FU routing, MULT occupancy,
// squash and asynchronous reset behaviour.
module tb_rs_issue_sched;

  logic              clk;
  logic              rst_ni;
  logic [2:0][15:0]  alloc_vec;
  logic [15:0]       entry_ready;
  logic [15:0][1:0]  entryFu;
  logic [15:0][1:0]  fuStage;
  logic [1:0]        ls_ready;
  logic              squash;
  logic [15:0]       issue_en;
  logic [2:0]        issue_valid;
  logic [2:0][3:0]   issue_idx;
  logic [2:0][2:0]   issue_fu;
  logic [1:0]        mult_busy;

  int checkCount = 0;
  int errCount   = 0;

  localparam logic [1:0] ALU = 2'b00, LS = 2'b01, MUL = 2'b10, BR = 2'b11;

  rs_issue_sched #(.RS_SIZE(16), .IDXW(4), .MULT_LAT(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .alloc_vec_i   (alloc_vec),
    .entry_ready_i (entry_ready),
    .entry_fu_i    (entryFu),
    .ls_ready_i    (ls_ready),
    .squash_i      (squash),
    .issue_en_o    (issue_en),
    .issue_valid_o (issue_valid),
    .issue_idx_o   (issue_idx),
    .issue_fu_o    (issue_fu),
    .mult_busy_o   (mult_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] oh(input int n);
    logic [15:0] v;
    v = 16'd1;
    return v << n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectIssue(input string tag, input logic [2:0] v, input logic [11:0] idx,
                             input logic [8:0] fu, input logic [15:0] en);
    checkOutput({tag, "/valid"}, 32'(issue_valid), 32'(v));
    checkOutput({tag, "/idx"},   32'(issue_idx),   32'(idx));
    checkOutput({tag, "/fu"},    32'(issue_fu),    32'(fu));
    checkOutput({tag, "/en"},    32'(issue_en),    32'(en));
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
  task automatic applyStimulus(input logic [15:0] a2, input logic [15:0] a1, input logic [15:0] a0,
                               input logic [15:0] ready, input logic [1:0] ls, input logic sq);
    @(negedge clk);
    alloc_vec   = {a2, a1, a0};
    entry_ready = ready;
    entryFu     = fuStage;
    ls_ready    = ls;
    squash      = sq;
    #2;
  endtask

  initial begin
    rst_ni      = 1'b0;
    alloc_vec   = '0;
    entry_ready = 16'hFFFF;
    fuStage     = '0;
    entryFu     = '0;
    ls_ready    = 2'b11;
    squash      = 1'b0;
    #3;
    expectIssue("reset0", 3'b000, 12'h000, 9'd0, 16'h0000);
    checkOutput("reset0/busy", 32'(mult_busy), 32'd0);
    @(negedge clk);
    rst_ni      = 1'b1;
    entry_ready = '0;

    // Allocation order within one cycle: slot 2 oldest.
    applyStimulus(oh(5), oh(9), oh(2), 16'h0000, 2'b11, 1'b0);
    checkOutput("alloc/none", 32'(issue_valid), 32'd0);
    applyStimulus('0, '0, '0, oh(5) | oh(9) | oh(2), 2'b11, 1'b0);
    expectIssue("slotorder", 3'b111, {4'd2, 4'd9, 4'd5}, {3'd2, 3'd1, 3'd0}, 16'h0224);

    // Four ALUs, ages 3 > 7 > 1 > 0.
    applyStimulus(oh(3), oh(7), oh(1), 16'h0000, 2'b11, 1'b0);
    applyStimulus(oh(0), '0, '0, 16'h0000, 2'b11, 1'b0);
    applyStimulus('0, '0, '0, oh(0) | oh(1) | oh(3) | oh(7), 2'b11, 1'b0);
    expectIssue("alu4", 3'b111, {4'd1, 4'd7, 4'd3}, {3'd2, 3'd1, 3'd0}, 16'h008A);
    applyStimulus('0, '0, '0, oh(0), 2'b11, 1'b0);
    expectIssue("alu4next", 3'b001, 12'h000, 9'd0, 16'h0001);

    // Three MULTs plus one ALU; MULT_LAT = 4.
    fuStage[4] = MUL; fuStage[6] = MUL; fuStage[8] = MUL; fuStage[10] = ALU; fuStage[12] = MUL;
    applyStimulus(oh(4), oh(6), oh(8), 16'h0000, 2'b11, 1'b0);
    applyStimulus(oh(10), '0, '0, 16'h0000, 2'b11, 1'b0);
    applyStimulus('0, '0, '0, oh(4) | oh(6) | oh(8) | oh(10), 2'b11, 1'b0);
    expectIssue("mult0", 3'b111, {4'd10, 4'd6, 4'd4}, {3'd0, 3'd6, 3'd5}, 16'h0450);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus('0, '0, '0, oh(8), 2'b11, 1'b0);
      checkOutput($sformatf("multwait%0d/valid", c), 32'(issue_valid), 32'd0);
      checkOutput($sformatf("multwait%0d/busy", c), 32'(mult_busy), 32'd3);
    end
    applyStimulus('0, '0, '0, oh(8), 2'b11, 1'b0);
    expectIssue("mult4", 3'b001, 12'h008, 9'd5, 16'h0100);
    checkOutput("mult4/busy", 32'(mult_busy), 32'd0);
    applyStimulus('0, '0, '0, oh(12), 2'b11, 1'b0);
    expectIssue("mult5", 3'b001, 12'h00C, 9'd6, 16'h1000);
    checkOutput("mult5/busy", 32'(mult_busy), 32'd1);

    // LS binding follows ls_ready; BR fills in behind skipped LS entries.
    fuStage[1] = LS; fuStage[2] = LS; fuStage[3] = BR;
    applyStimulus(oh(1), oh(2), oh(3), 16'h0000, 2'b10, 1'b0);
    applyStimulus('0, '0, '0, oh(1) | oh(2) | oh(3), 2'b10, 1'b0);
    expectIssue("ls10", 3'b011, {4'd0, 4'd3, 4'd1}, {3'd0, 3'd7, 3'd4}, 16'h000A);
    applyStimulus('0, '0, '0, oh(1) | oh(2) | oh(3), 2'b11, 1'b0);
    expectIssue("ls11", 3'b111, {4'd3, 4'd2, 4'd1}, {3'd7, 3'd4, 3'd3}, 16'h000E);
    applyStimulus('0, '0, '0, oh(1) | oh(2) | oh(3), 2'b00, 1'b0);
    expectIssue("ls00", 3'b001, 12'h003, 9'd7, 16'h0008);

    // Squash: no issue, ages cleared, allocation ignored, MULT keeps counting.
    fuStage[11] = MUL; fuStage[14] = ALU; fuStage[2] = ALU; fuStage[6] = ALU;
    applyStimulus(oh(14), oh(2), '0, oh(11), 2'b11, 1'b0);
    expectIssue("presquash", 3'b001, 12'h00B, 9'd5, 16'h0800);
    applyStimulus('0, '0, oh(1), oh(14) | oh(2) | oh(6), 2'b11, 1'b1);
    expectIssue("squash", 3'b000, 12'h000, 9'd0, 16'h0000);
    checkOutput("squash/busy", 32'(mult_busy), 32'd1);
    fuStage[1] = BR; fuStage[2] = BR; fuStage[14] = BR; fuStage[0] = BR; fuStage[5] = BR;
    applyStimulus('0, '0, '0, oh(2) | oh(14), 2'b11, 1'b0);
    expectIssue("cleared", 3'b001, 12'h002, 9'd7, 16'h0004);
    checkOutput("cleared/busy", 32'(mult_busy), 32'd1);
    applyStimulus(oh(0), '0, '0, oh(1) | oh(2), 2'b11, 1'b0);
    expectIssue("allocignored", 3'b001, 12'h001, 9'd7, 16'h0002);
    applyStimulus(oh(5), '0, '0, 16'h0000, 2'b11, 1'b0);
    checkOutput("postsquash/busy", 32'(mult_busy), 32'd0);
    applyStimulus('0, '0, '0, oh(0) | oh(5), 2'b11, 1'b0);
    expectIssue("first0", 3'b001, 12'h000, 9'd7, 16'h0001);

    // Asynchronous reset while both MULT counters sit at 3.
    applyStimulus('0, '0, '0, oh(4) | oh(12), 2'b11, 1'b0);
    expectIssue("twomult", 3'b011, {4'd0, 4'd12, 4'd4}, {3'd0, 3'd6, 3'd5}, 16'h1010);
    applyStimulus('0, '0, '0, oh(10), 2'b11, 1'b0);
    checkOutput("prereset/busy", 32'(mult_busy), 32'd3);
    checkOutput("prereset/valid", 32'(issue_valid), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    expectIssue("midreset", 3'b000, 12'h000, 9'd0, 16'h0000);
    checkOutput("midreset/busy", 32'(mult_busy), 32'd0);
    @(negedge clk);
    rst_ni      = 1'b1;
    entry_ready = '0;
    fuStage[9]  = BR;
    applyStimulus(oh(9), '0, '0, 16'h0000, 2'b11, 1'b0);
    checkOutput("postreset/busy", 32'(mult_busy), 32'd0);
    applyStimulus(oh(2), '0, '0, 16'h0000, 2'b11, 1'b0);
    applyStimulus('0, '0, '0, oh(2) | oh(9), 2'b11, 1'b0);
    expectIssue("postreset/oldest", 3'b001, 12'h009, 9'd7, 16'h0200);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
